// File: rtl/crc16_frame_appender.sv
// rtl/crc16_frame_appender.sv - forwards a payload byte stream and appends a 16-bit CRC
// taken from an external CRC engine, with a single-stage output register.
module crc16_frame_appender #(
  parameter int CRC_LAT   = 2,
  parameter bit MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  crc_data,
  output logic        crc_data_valid,
  input  logic [15:0] crc_in,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PAYLOAD, WAIT, CRC1, CRC2} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [15:0] hold;
  logic        out_free;
  logic        accept;
  logic [7:0]  first_byte;
  logic [7:0]  second_byte;

  assign out_free    = !out_valid || out_ready;
  // Gated with rst_n so in_ready reads 0 while reset is held.
  assign in_ready    = rst_n && (state == IDLE || state == PAYLOAD) && out_free;
  assign accept      = in_valid && in_ready;
  assign busy        = (state != IDLE);
  assign first_byte  = MSB_FIRST ? hold[15:8] : hold[7:0];
  assign second_byte = MSB_FIRST ? hold[7:0]  : hold[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= 4'd0;
      hold           <= 16'd0;
      out_data       <= 8'd0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      crc_data       <= 8'd0;
      crc_data_valid <= 1'b0;
    end else begin
      crc_data_valid <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        IDLE, PAYLOAD: begin
          if (accept) begin
            out_data       <= in_data;
            out_valid      <= 1'b1;
            out_last       <= 1'b0;
            crc_data       <= in_data;
            crc_data_valid <= 1'b1;
            if (in_last) begin
              state <= WAIT;
              count <= 4'(CRC_LAT);
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        WAIT: begin
          // Capture on the edge where the countdown reaches zero.
          if (count <= 4'd1) begin
            count <= 4'd0;
            hold  <= crc_in;
            state <= CRC1;
          end else begin
            count <= count - 4'd1;
          end
        end
        CRC1: begin
          if (out_free) begin
            out_data  <= first_byte;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= CRC2;
          end
        end
        CRC2: begin
          if (out_free) begin
            out_data  <= second_byte;
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_frame_appender.sv
// tb/tb_crc16_frame_appender.sv - scoreboard bench driving two appenders (MSB and LSB first)
// with identical random frames and checking framed output, CRC feed and timing.
module tb_crc16_frame_appender;

  localparam int CRC_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic [15:0] crc_in;
  logic        out_ready;

  logic [7:0]  od [2];
  logic        ov [2];
  logic        ol [2];
  logic [7:0]  cd [2];
  logic        cdv [2];
  logic        ir [2];
  logic        bsy [2];

  always #5 clk = ~clk;

  crc16_frame_appender #(.CRC_LAT(CRC_LAT), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir[0]), .crc_data(cd[0]), .crc_data_valid(cdv[0]), .crc_in(crc_in),
    .out_data(od[0]), .out_valid(ov[0]), .out_last(ol[0]), .out_ready(out_ready), .busy(bsy[0])
  );

  crc16_frame_appender #(.CRC_LAT(CRC_LAT), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir[1]), .crc_data(cd[1]), .crc_data_valid(cdv[1]), .crc_in(crc_in),
    .out_data(od[1]), .out_valid(ov[1]), .out_last(ol[1]), .out_ready(out_ready), .busy(bsy[1])
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          mode     = 0;
  int          last_acc_cyc = 0;
  bit          prev_clean = 0;
  bit          tail = 0;
  logic [7:0]  frame_bytes [16];
  logic [15:0] crc_val;
  logic [8:0]  exp_q [2][$];
  logic [7:0]  crc_q [2][$];
  bit          stall_prev [2];
  logic [8:0]  stall_val [2];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // out_ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = random.
  task automatic tick();
    @(negedge clk);
    cyc++;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'($urandom);
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic send_frame(input int n, input int abort_after, input bit gaps);
    int waited;
    bit acc;
    crc_in = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      if (abort_after != 0 && i == abort_after) return;
      acc = 0;
      waited = 0;
      while (!acc) begin
        tick();
        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data  = in_valid ? frame_bytes[i] : 8'($urandom);
        in_last  = in_valid ? (i == n - 1) : 1'($urandom);
        if (in_valid && ir[0]) begin
          acc = 1;
          for (int k = 0; k < 2; k++) begin
            exp_q[k].push_back({1'b0, in_data});
            crc_q[k].push_back(in_data);
          end
          if (i == 0 && prev_clean && mode == 0 && !gaps)
            check("b2b_gap", 32'(cyc - last_acc_cyc), 32'(CRC_LAT + 3));
        end else if (++waited > 500) begin
          check("accept_timeout", 32'(waited), 32'd0);
          in_valid = 1'b0;
          return;
        end
      end
    end
    last_acc_cyc = cyc;
    exp_q[0].push_back({1'b0, crc_val[15:8]});
    exp_q[0].push_back({1'b1, crc_val[7:0]});
    exp_q[1].push_back({1'b0, crc_val[7:0]});
    exp_q[1].push_back({1'b1, crc_val[15:8]});
    // Engine result settles during the strobe cycle and is scrambled right after capture.
    tick();
    idle_in();
    crc_in = crc_val;
    tail = 1;
    repeat (CRC_LAT) begin
      tick();
      idle_in();
    end
    crc_in = 16'($urandom);
    in_valid = 1'b0;
    in_last = 1'b0;
    prev_clean = (mode == 0 && !gaps);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_out"}, {od[k], ov[k], ol[k]}, 32'd0);
      check({tag, "_crc"}, {cd[k], cdv[k]}, 32'd0);
      check({tag, "_busy_ready"}, {bsy[k], ir[k]}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (stall_prev[k])
          check("stall_stable", {ov[k], ol[k], od[k]}, {1'b1, stall_val[k]});
        if (ov[k] && out_ready) begin
          if (exp_q[k].size() == 0) check("unexpected_out", {ol[k], od[k]}, 32'h1ff);
          else check("out_byte", {ol[k], od[k]}, exp_q[k].pop_front());
        end
        stall_prev[k] = ov[k] && !out_ready;
        stall_val[k]  = {ol[k], od[k]};
        if (cdv[k]) begin
          if (crc_q[k].size() == 0) check("unexpected_crc_feed", cd[k], 32'h1ff);
          else check("crc_feed", cd[k], crc_q[k].pop_front());
        end
      end
      if (tail) begin
        if (ov[0] && ol[0]) tail = 0;
        else begin
          check("in_ready_tail", {ir[0], ir[1]}, 32'd0);
          check("busy_tail", {bsy[0], bsy[1]}, 32'd3);
        end
      end
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
    crc_in = 16'd0; out_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("first_ready", {ir[0], ir[1]}, 32'd3);

    mode = 0;
    frame_bytes[0] = 8'h31; crc_val = 16'hBEEF;
    send_frame(1, 0, 0);
    frame_bytes[0] = 8'h01; frame_bytes[1] = 8'h02; frame_bytes[2] = 8'h03; frame_bytes[3] = 8'h04;
    crc_val = 16'h1234;
    send_frame(4, 0, 0);
    frame_bytes[0] = 8'h40; crc_val = 16'h5A5A;
    send_frame(1, 0, 0);

    mode = 1;
    frame_bytes[0] = 8'hAA; frame_bytes[1] = 8'hBB; frame_bytes[2] = 8'hCC;
    crc_val = 16'hBEEF;
    send_frame(3, 0, 0);

    frame_bytes[0] = 8'h11; frame_bytes[1] = 8'h22; frame_bytes[2] = 8'h33; frame_bytes[3] = 8'h44;
    crc_val = 16'hC0DE;
    send_frame(4, 2, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      crc_q[k].delete();
      stall_prev[k] = 0;
    end
    tail = 0;
    prev_clean = 0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {ir[0], ir[1]}, 32'd3);

    mode = 0;
    frame_bytes[0] = 8'h55; crc_val = 16'h9876;
    send_frame(1, 0, 0);

    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 8);
      mode = (f < 6) ? 0 : $urandom_range(0, 2);
      for (int i = 0; i < n; i++) frame_bytes[i] = 8'($urandom);
      crc_val = 16'($urandom);
      send_frame(n, 0, (f < 6) ? 1'b0 : 1'($urandom));
    end

    mode = 0;
    waited = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && waited < 200) begin
      tick();
      waited++;
    end
    check("drain", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    tick();
    tick();
    check("busy_idle", {bsy[0], bsy[1]}, 32'd0);
    check("crc_feed_drained", 32'(crc_q[0].size() + crc_q[1].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
